// File: rtl/isa_pkg.sv
// Shared ISA definitions for the execute stage: op bundles and instruction lengths.
// Optional word ops (addw/subw/sllw/srlw/sraw) are present only when ALU_WORD_OPS_EN is defined.
package isa_pkg;

    localparam logic [63:0] INST_LEN_C = 64'd2;
    localparam logic [63:0] INST_LEN   = 64'd4;

    typedef struct packed {
        logic add;
        logic sub;
        logic and_op;
        logic or_op;
        logic xor_op;
        logic sll;
        logic srl;
        logic sra;
        logic slt;
        logic sltu;
        logic lui;
        logic auipc;
`ifdef ALU_WORD_OPS_EN
        logic addw;
        logic subw;
        logic sllw;
        logic srlw;
        logic sraw;
`endif
    } alu_ops_t;

    // Opaque memory-op codes; zero means no access.
    typedef struct packed {
        logic [3:0] load_op;
        logic [3:0] store_op;
    } io_ops_t;

    typedef struct packed {
        logic beq;
        logic bne;
        logic blt;
        logic bge;
        logic bltu;
        logic bgeu;
        logic jal;
        logic jalr;
    } bj_ops_t;

    typedef struct packed {
        logic ecall;
        logic ebreak;
    } sys_ops_t;

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage; one-hot op select, zero when no op is set.
// Word ops are built only when ALU_WORD_OPS_EN is defined.
module alu
    import isa_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  alu_ops_t          ops,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    output logic [XLEN-1:0]   result
);

    logic [5:0] shamt;
    assign shamt = b[5:0];

    // Ops are one-hot, so OR-ing the gated terms selects exactly one result.
    always_comb begin
        result = '0;
        if (ops.add)    result |= a + b;
        if (ops.sub)    result |= a - b;
        if (ops.and_op) result |= a & b;
        if (ops.or_op)  result |= a | b;
        if (ops.xor_op) result |= a ^ b;
        if (ops.sll)    result |= a << shamt;
        if (ops.srl)    result |= a >> shamt;
        if (ops.sra)    result |= XLEN'($signed(a) >>> shamt);
        if (ops.slt)    result |= {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
        if (ops.sltu)   result |= {{(XLEN-1){1'b0}}, a < b};
        if (ops.lui)    result |= imm;
        if (ops.auipc)  result |= pc + imm;
`ifdef ALU_WORD_OPS_EN
        if (ops.addw)   result |= sext32(a[31:0] + b[31:0]);
        if (ops.subw)   result |= sext32(a[31:0] - b[31:0]);
        if (ops.sllw)   result |= sext32(a[31:0] << b[4:0]);
        if (ops.srlw)   result |= sext32(a[31:0] >> b[4:0]);
        if (ops.sraw)   result |= sext32(32'($signed(a[31:0]) >>> b[4:0]));
`endif
    end

endmodule

// File: rtl/execute_stage.sv
// RV64 execute stage: ALU, branch/jump resolution, trap detection and the EX/MA register.
// Define ALU_WORD_OPS_EN to enable the 32-bit word ALU ops.
module execute_stage
    import isa_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              stall,
    input  alu_ops_t          alu_ops,
    input  io_ops_t           io_ops,
    input  bj_ops_t           bj_ops,
    input  sys_ops_t          sys_ops,
    input  logic              compressed,
    input  logic [XLEN-1:0]   pc,
    input  logic [4:0]        rd,
    input  logic [XLEN-1:0]   imm,
    input  logic              with_imm,
    input  logic [XLEN-1:0]   fwd1,
    input  logic [XLEN-1:0]   fwd2,
    output logic [XLEN-1:0]   trap_pc,
    output logic              trap_en,
    output logic [XLEN-1:0]   bj_pc,
    output logic              bj_en,
    output io_ops_t           io_ops_out,
    output logic [XLEN-1:0]   pc_out,
    output logic [4:0]        rd_out,
    output logic [XLEN-1:0]   result_out,
    output logic [XLEN-1:0]   data2_out
);

    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] result_next;
    logic [4:0]      rd_next;
    logic            is_jump;
    logic            branch_taken;
    logic            trap_req;
    logic            flow_ok;
    logic            eq, lt, ltu;

    io_ops_t         io_ops_reg;
    logic [XLEN-1:0] pc_reg;
    logic [4:0]      rd_reg;
    logic [XLEN-1:0] result_reg;
    logic [XLEN-1:0] data2_reg;

    assign op_b = with_imm ? imm : fwd2;

    alu #(.XLEN(XLEN)) u_alu (
        .ops    (alu_ops),
        .a      (fwd1),
        .b      (op_b),
        .pc     (pc),
        .imm    (imm),
        .result (alu_result)
    );

    assign eq  = (fwd1 == fwd2);
    assign lt  = ($signed(fwd1) < $signed(fwd2));
    assign ltu = (fwd1 < fwd2);

    assign is_jump      = bj_ops.jal | bj_ops.jalr;
    assign branch_taken = (bj_ops.beq  &  eq)  | (bj_ops.bne  & ~eq)
                        | (bj_ops.blt  &  lt)  | (bj_ops.bge  & ~lt)
                        | (bj_ops.bltu &  ltu) | (bj_ops.bgeu & ~ltu);
    assign trap_req     = sys_ops.ecall | sys_ops.ebreak;
    assign flow_ok      = ~clear & ~stall;

    // A trap takes precedence over any simultaneous redirect.
    assign trap_en = trap_req & flow_ok;
    assign trap_pc = pc;
    assign bj_en   = (is_jump | branch_taken) & flow_ok & ~trap_req;
    assign bj_pc   = bj_ops.jalr ? ((fwd1 + imm) & ~{{(XLEN-1){1'b0}}, 1'b1})
                                 : (pc + imm);

    assign result_next = is_jump ? (pc + (compressed ? XLEN'(INST_LEN_C) : XLEN'(INST_LEN)))
                                 : alu_result;
    // Trapping instructions retire with rd=0 so they never write the register file.
    assign rd_next     = trap_req ? 5'd0 : rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_ops_reg <= '0;
            pc_reg     <= '0;
            rd_reg     <= '0;
            result_reg <= '0;
            data2_reg  <= '0;
        end else if (clear) begin
            io_ops_reg <= '0;
            pc_reg     <= '0;
            rd_reg     <= '0;
            result_reg <= '0;
            data2_reg  <= '0;
        end else if (!stall) begin
            io_ops_reg <= io_ops;
            pc_reg     <= pc;
            rd_reg     <= rd_next;
            result_reg <= result_next;
            data2_reg  <= fwd2;
        end
    end

    assign io_ops_out = io_ops_reg;
    assign pc_out     = pc_reg;
    assign rd_out     = rd_reg;
    assign result_out = result_reg;
    assign data2_out  = data2_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Directed scoreboard bench for execute_stage: expected EX/MA contents are queued at issue
// and popped one cycle later; redirect/trap outputs are checked in the issue cycle.
module tb_execute_stage;
    import isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear, stall, compressed, with_imm;
    alu_ops_t    alu_ops;
    io_ops_t     io_ops;
    bj_ops_t     bj_ops;
    sys_ops_t    sys_ops;
    logic [63:0] pc, imm, fwd1, fwd2;
    logic [4:0]  rd;
    logic [63:0] trap_pc, bj_pc, pc_out, result_out, data2_out;
    logic        trap_en, bj_en;
    io_ops_t     io_ops_out;
    logic [4:0]  rd_out;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] result;
        logic [63:0] data2;
        io_ops_t     io;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    exp_t zero_exp;
    int   tests = 0;
    int   fails = 0;

    execute_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .stall      (stall),
        .alu_ops    (alu_ops),
        .io_ops     (io_ops),
        .bj_ops     (bj_ops),
        .sys_ops    (sys_ops),
        .compressed (compressed),
        .pc         (pc),
        .rd         (rd),
        .imm        (imm),
        .with_imm   (with_imm),
        .fwd1       (fwd1),
        .fwd2       (fwd2),
        .trap_pc    (trap_pc),
        .trap_en    (trap_en),
        .bj_pc      (bj_pc),
        .bj_en      (bj_en),
        .io_ops_out (io_ops_out),
        .pc_out     (pc_out),
        .rd_out     (rd_out),
        .result_out (result_out),
        .data2_out  (data2_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        clear = 0; stall = 0; compressed = 0; with_imm = 0;
        alu_ops = '0; io_ops = '0; bj_ops = '0; sys_ops = '0;
        pc = '0; imm = '0; fwd1 = '0; fwd2 = '0; rd = '0;
    endtask

    // Expected EX/MA load from the inputs currently driven.
    task automatic push_load(input logic [63:0] res, input logic [4:0] rdv);
        exp_t e;
        e.pc = pc; e.rd = rdv; e.result = res; e.data2 = fwd2; e.io = io_ops;
        exp_q.push_back(e);
    endtask

    task automatic check_regs(input string tag, input exp_t e);
        chk({tag, ".pc"},     pc_out,              e.pc);
        chk({tag, ".rd"},     64'(rd_out),         64'(e.rd));
        chk({tag, ".result"}, result_out,          e.result);
        chk({tag, ".data2"},  data2_out,           e.data2);
        chk({tag, ".io"},     64'(io_ops_out),     64'(e.io));
    endtask

    task automatic step_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_regs(tag, e);
            last_exp = e;
            $display("[TB] %s: result_out=%h rd_out=%0d pc_out=%h", tag, result_out, rd_out, pc_out);
        end
    endtask

    initial begin
        zero_exp = '{pc: '0, rd: '0, result: '0, data2: '0, io: '0};
        last_exp = zero_exp;
        idle();
        #12;
        check_regs("reset", zero_exp);
        rst_n = 1;
        @(posedge clk); #1;

        idle(); alu_ops.add = 1; with_imm = 1; fwd1 = 64'h10; imm = 64'h8;
        rd = 5'd5; pc = 64'h40; fwd2 = 64'h99; io_ops.load_op = 4'd3;
        #1; chk("add.bj_en", 64'(bj_en), 64'd0); chk("add.trap_en", 64'(trap_en), 64'd0);
        push_load(64'h18, 5'd5); step_check("add_imm");

        idle(); alu_ops.sub = 1; fwd1 = 64'd5; fwd2 = 64'd7; rd = 5'd6; pc = 64'h44;
        push_load(64'hFFFF_FFFF_FFFF_FFFE, 5'd6); step_check("sub");

        idle(); alu_ops.slt = 1; fwd1 = '1; fwd2 = 64'd1; rd = 5'd8; pc = 64'h48;
        push_load(64'd1, 5'd8); step_check("slt");

        idle(); alu_ops.sltu = 1; fwd1 = '1; fwd2 = 64'd1; rd = 5'd9; pc = 64'h4C;
        push_load(64'd0, 5'd9); step_check("sltu");

        idle(); alu_ops.sra = 1; with_imm = 1; fwd1 = 64'h8000_0000_0000_0000; imm = 64'd4;
        fwd2 = 64'h1234; rd = 5'd10; pc = 64'h50;
        push_load(64'hF800_0000_0000_0000, 5'd10); step_check("sra");

        idle(); alu_ops.auipc = 1; with_imm = 1; pc = 64'h3000; imm = 64'h120; rd = 5'd11;
        push_load(64'h3120, 5'd11); step_check("auipc");

        idle(); bj_ops.jalr = 1; with_imm = 1; compressed = 1; pc = 64'h1000;
        fwd1 = 64'h2001; imm = 64'd4; rd = 5'd1;
        #1; chk("jalr.bj_en", 64'(bj_en), 64'd1); chk("jalr.bj_pc", bj_pc, 64'h2004);
        push_load(64'h1002, 5'd1); step_check("jalr");

        idle(); bj_ops.beq = 1; pc = 64'h100; imm = -64'sd8; fwd1 = 64'd3; fwd2 = 64'd3; rd = 5'd0;
        #1; chk("beq_t.bj_en", 64'(bj_en), 64'd1); chk("beq_t.bj_pc", bj_pc, 64'hF8);
        push_load(64'd0, 5'd0); step_check("beq_taken");

        idle(); bj_ops.beq = 1; pc = 64'h100; imm = -64'sd8; fwd1 = 64'd3; fwd2 = 64'd4;
        #1; chk("beq_nt.bj_en", 64'(bj_en), 64'd0);
        push_load(64'd0, 5'd0); step_check("beq_not_taken");

        idle(); bj_ops.bltu = 1; pc = 64'h200; imm = 64'h40; fwd1 = 64'd1; fwd2 = '1;
        #1; chk("bltu.bj_en", 64'(bj_en), 64'd1); chk("bltu.bj_pc", bj_pc, 64'h240);
        push_load(64'd0, 5'd0); step_check("bltu");

        idle(); stall = 1; bj_ops.beq = 1; alu_ops.add = 1; pc = 64'h500; imm = 64'h10;
        fwd1 = 64'd3; fwd2 = 64'd3; rd = 5'd12;
        #1; chk("stall.bj_en", 64'(bj_en), 64'd0);
        exp_q.push_back(last_exp); step_check("stall_hold");

        idle(); clear = 1; stall = 1; bj_ops.jal = 1; pc = 64'h600; imm = 64'h20; rd = 5'd13;
        fwd2 = 64'h77; io_ops.store_op = 4'd2;
        #1; chk("clear.bj_en", 64'(bj_en), 64'd0);
        exp_q.push_back(zero_exp); step_check("clear_bubble");

        idle(); sys_ops.ecall = 1; pc = 64'h80; rd = 5'd7; fwd2 = 64'h55;
        #1; chk("ecall.trap_en", 64'(trap_en), 64'd1); chk("ecall.trap_pc", trap_pc, 64'h80);
        push_load(64'd0, 5'd0); step_check("ecall");

        idle(); sys_ops.ebreak = 1; bj_ops.jal = 1; pc = 64'h200; imm = 64'h40; rd = 5'd3;
        #1; chk("trapjal.trap_en", 64'(trap_en), 64'd1); chk("trapjal.bj_en", 64'(bj_en), 64'd0);
        push_load(64'h204, 5'd0); step_check("ebreak_jal");

        idle(); stall = 1; sys_ops.ecall = 1; pc = 64'h90;
        #1; chk("trapstall.trap_en", 64'(trap_en), 64'd0);
        exp_q.push_back(last_exp); step_check("ecall_stall");

        idle(); alu_ops.xor_op = 1; fwd1 = 64'hF0F0; fwd2 = 64'h0FF0; rd = 5'd14; pc = 64'h700;
        push_load(64'hFF00, 5'd14); step_check("xor");

        #2; rst_n = 0; #1;
        check_regs("async_reset", zero_exp);
        last_exp = zero_exp;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        idle(); alu_ops.add = 1; with_imm = 1; fwd1 = 64'h100; imm = 64'h23; rd = 5'd2; pc = 64'h800;
        push_load(64'h123, 5'd2); step_check("add_after_reset");

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
